// File: rtl/conv_sched_pkg.sv
// Shared types and sizing helpers for the conv row scheduler.
package conv_sched_pkg;

  typedef enum logic [1:0] {
    StLoad,
    StStart,
    StWait,
    StOut
  } sched_state_e;

  function automatic int unsigned row_bits(int unsigned d, int unsigned dw, int unsigned w);
    return d * dw * (w + 2);
  endfunction

  // Bits needed to represent every value in 0..max_val.
  function automatic int unsigned cnt_bits(int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/conv_row_window.sv
// Three-row sliding window feeding the conv datapath (top, middle, bottom).
module conv_row_window #(
  parameter int unsigned RowBits = 448
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               shift_i,
  input  logic [RowBits-1:0] row_i,
  output logic [RowBits-1:0] image0_o,
  output logic [RowBits-1:0] image1_o,
  output logic [RowBits-1:0] image2_o
);

  logic [RowBits-1:0] img0_q, img0_d;
  logic [RowBits-1:0] img1_q, img1_d;
  logic [RowBits-1:0] img2_q, img2_d;

  always_comb begin
    img0_d = img0_q;
    img1_d = img1_q;
    img2_d = img2_q;
    if (clear_i) begin
      img0_d = '0;
      img1_d = '0;
      img2_d = '0;
    end else if (shift_i) begin
      img0_d = img1_q;
      img1_d = img2_q;
      img2_d = row_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      img0_q <= '0;
      img1_q <= '0;
      img2_q <= '0;
    end else begin
      img0_q <= img0_d;
      img1_q <= img1_d;
      img2_q <= img2_d;
    end
  end

  assign image0_o = img0_q;
  assign image1_o = img1_q;
  assign image2_o = img2_q;

endmodule

// File: rtl/conv_row_sched.sv
// Row scheduler: buffers input rows into a 3-row window, launches the conv
// datapath once per output row and streams results downstream.
module conv_row_sched
  import conv_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned D          = 4,
  parameter int unsigned W          = 12,
  parameter int unsigned H          = 12,
  parameter int unsigned OUT_BITS   = 384,
  parameter int unsigned TIMEOUT    = 64,
  localparam int unsigned ROW_BITS  = row_bits(D, DATA_WIDTH, W)
) (
  input  logic                clk,
  input  logic                rstn_i,
  input  logic [ROW_BITS-1:0] row_i,
  input  logic                row_valid_i,
  output logic                row_ready_o,
  output logic [ROW_BITS-1:0] image0_o,
  output logic [ROW_BITS-1:0] image1_o,
  output logic [ROW_BITS-1:0] image2_o,
  output logic                image_start_o,
  input  logic [OUT_BITS-1:0] conv_out_i,
  input  logic                conv_done_i,
  output logic [OUT_BITS-1:0] out_row_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                out_last_o,
  output logic                frame_done_o,
  output logic                timeout_err_o,
  output logic                busy_o
);

  localparam int unsigned InW   = cnt_bits(H);
  localparam int unsigned OutW  = cnt_bits(H - 1);
  localparam int unsigned WaitW = cnt_bits(TIMEOUT);

  localparam logic [InW-1:0]   InFull   = InW'(H);
  localparam logic [InW-1:0]   InOne    = InW'(1);
  localparam logic [OutW-1:0]  OutLast  = OutW'(H - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  sched_state_e        state_q, state_d;
  logic [InW-1:0]      in_cnt_q, in_cnt_d;
  logic [OutW-1:0]     out_cnt_q, out_cnt_d;
  logic [WaitW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [OUT_BITS-1:0] out_row_q, out_row_d;
  logic                timeout_q, timeout_d;
  logic                frame_done_q, frame_done_d;

  logic                win_shift, win_clear;
  logic [ROW_BITS-1:0] win_row;

  conv_row_window #(
    .RowBits(ROW_BITS)
  ) u_window (
    .clk_i   (clk),
    .rst_i   (rstn_i),
    .clear_i (win_clear),
    .shift_i (win_shift),
    .row_i   (win_row),
    .image0_o(image0_o),
    .image1_o(image1_o),
    .image2_o(image2_o)
  );

  always_comb begin
    state_d      = state_q;
    in_cnt_d     = in_cnt_q;
    out_cnt_d    = out_cnt_q;
    wait_cnt_d   = '0;
    out_row_d    = out_row_q;
    timeout_d    = timeout_q;
    frame_done_d = 1'b0;
    win_shift    = 1'b0;
    win_clear    = 1'b0;
    win_row      = row_i;

    unique case (state_q)
      StLoad: begin
        if (row_valid_i) begin
          win_shift = 1'b1;
          if (in_cnt_q != InFull) in_cnt_d = in_cnt_q + 1'b1;
          // Post-accept count reaches 2: window holds enough rows for a result.
          if (in_cnt_q >= InOne) state_d = StStart;
        end
      end
      StStart: state_d = StWait;
      StWait: begin
        if (conv_done_i) begin
          out_row_d = conv_out_i;
          state_d   = StOut;
        end else if (wait_cnt_q == WaitLast) begin
          timeout_d = 1'b1;
          win_clear = 1'b1;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = StLoad;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StOut: begin
        if (out_ready_i) begin
          if (out_cnt_q == OutLast) begin
            frame_done_d = 1'b1;
            win_clear    = 1'b1;
            in_cnt_d     = '0;
            out_cnt_d    = '0;
            state_d      = StLoad;
          end else begin
            out_cnt_d = out_cnt_q + 1'b1;
            if (in_cnt_q == InFull) begin
              // All input rows consumed: bottom zero pad feeds the last result.
              win_shift = 1'b1;
              win_row   = '0;
              state_d   = StStart;
            end else begin
              state_d = StLoad;
            end
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or posedge rstn_i) begin
    if (rstn_i) begin
      state_q      <= StLoad;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      out_row_q    <= '0;
      timeout_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      out_row_q    <= out_row_d;
      timeout_q    <= timeout_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign row_ready_o   = (state_q == StLoad) && !rstn_i;
  assign image_start_o = (state_q == StStart);
  assign out_valid_o   = (state_q == StOut);
  assign out_last_o    = out_valid_o && (out_cnt_q == OutLast);
  assign out_row_o     = out_row_q;
  assign frame_done_o  = frame_done_q;
  assign timeout_err_o = timeout_q;
  assign busy_o        = (state_q != StLoad) || (in_cnt_q != '0);

endmodule

// File: doc/conv_row_sched.md
CONV_ROW_SCHED -- requirements
Module: conv_row_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 8, bits per pixel channel.
REQ-002 Parameter D, default 4, input depth (channels per pixel).
REQ-003 Parameter W, default 12, output row width in pixels; input rows carry W+2 pixels, with zero pad columns already present.
REQ-004 Parameter H, default 12, rows per frame, both input and output.
REQ-005 Parameter OUT_BITS, default 384, width of one conv result row.
REQ-006 Parameter TIMEOUT, default 64, maximum cycles to wait for conv completion.
REQ-007 Derived ROW_BITS = D*DATA_WIDTH*(W+2) (448 at defaults).
REQ-008 Port clk, input, 1, single clock; all logic rising-edge.
REQ-009 Port rstn_i, input, 1, asynchronous active-high reset (name kept per codebase; asserted = 1).
REQ-010 Ports row_i / row_valid_i / row_ready_o, input / input / output, ROW_BITS / 1 / 1, upstream row stream, valid/ready handshake.
REQ-011 Ports image0_o, image1_o, image2_o, output, ROW_BITS each, 3-row window to conv datapath (top, middle, bottom).
REQ-012 Port image_start_o, output, 1, one-cycle start pulse to conv datapath.
REQ-013 Ports conv_out_i / conv_done_i, input / input, OUT_BITS / 1, conv result row and its done pulse.
REQ-014 Ports out_row_o / out_valid_o / out_ready_i / out_last_o, output / output / input / output, OUT_BITS / 1 / 1 / 1, downstream result stream; out_last_o marks row H-1.
REQ-015 Ports frame_done_o, timeout_err_o, busy_o, output, 1 each: frame-complete pulse, sticky timeout flag, activity status.

Function
REQ-016 FSM states: LOAD, START, WAIT, OUT; reset state LOAD.
REQ-017 Window shift on accept: image0<=image1, image1<=image2, image2<=new row (row_i or zero row).
REQ-018 Frame start: window all-zero; top zero pad row = initial image1.
REQ-019 LOAD: row_ready_o=1; accept on row_valid_i&row_ready_o; in_cnt++; go START once in_cnt>=2, else stay LOAD.
REQ-020 row_ready_o SHALL be 0 in START, WAIT, OUT; no row accepted there.
REQ-021 START: image_start_o=1 for exactly one cycle, window stable; next WAIT.
REQ-022 WAIT: on conv_done_i capture conv_out_i into out_row_o; go OUT; out_valid_o=1 from next cycle.
REQ-023 conv_done_i outside WAIT SHALL be ignored.
REQ-024 WAIT wait counter reaching TIMEOUT with no done: set timeout_err_o, abort frame (window cleared, counters zeroed), go LOAD.
REQ-025 OUT: hold out_row_o/out_valid_o until out_ready_i; out_last_o=1 when out_cnt==H-1.
REQ-026 After OUT handshake: if out_cnt==H-1, pulse frame_done_o one cycle, clear window/counters, go LOAD; else if in_cnt==H, shift in zero row (bottom pad), go START; else go LOAD.
REQ-027 Result y SHALL be computed from rows y-1, y, y+1, with out-of-range rows zero; H results per frame, in order.
REQ-028 busy_o=1 whenever state!=LOAD or in_cnt!=0.
REQ-029 Counters in_cnt 0..H, out_cnt 0..H-1; no wrap beyond; cleared at frame end.
REQ-030 timeout_err_o cleared only by reset.

Reset
REQ-031 rstn_i=1 SHALL asynchronously force: state LOAD, window zero, counters zero, out_row_o zero, all 1-bit outputs 0 except row_ready_o=1 after release.
REQ-032 Reset mid-frame SHALL discard all partial frame state; the next accepted row is row 0.

Structure
REQ-033 Package conv_sched_pkg holds FSM state encoding and ROW_BITS/counter-width localparam functions.
REQ-034 Sub-module conv_row_window (3-row shift register with synchronous clear) is natural; everything else is in conv_row_sched.

Verification
REQ-035 12 rows, row r all bytes r+1, conv_done 3 cycles after start, out_ready=1 -> 12 starts; start k shows image0/1/2 = rows k-1,k,k+1 (zero at edges); 12 outputs, out_last on the 12th, one frame_done.
REQ-036 Hold out_ready_i=0 for 10 cycles on output 5 -> out_row_o stable, out_valid_o held, row_ready_o=0, no extra image_start_o.
REQ-037 Suppress conv_done after start 3 -> timeout_err_o=1 at TIMEOUT cycles; next frame restarts from row 0 with zero top window.
REQ-038 Spurious conv_done_i in LOAD and OUT -> no state change; out_row_o unchanged.
REQ-039 Assert rstn_i after 6 rows -> all outputs at reset values immediately; a following full frame produces 12 correct outputs.
REQ-040 Gappy row_valid_i (1 of 3 cycles) -> identical output sequence to REQ-035.
